// File: rtl/warmboot_pkg.sv
// Shared types and sizing helpers for the iCE40 warmboot sequencer.
package warmboot_pkg;

  typedef enum logic [2:0] {IDLE, DETACH, PWROFF, ARM, FIRE} state_t;

  typedef logic [1:0] img_t;

  localparam img_t GOLDEN_IMAGE = 2'd0;

  // Counter width needed to hold max-1; never narrower than one bit.
  function automatic int cyc_w(input int max);
    return (max <= 2) ? 1 : $clog2(max);
  endfunction

endpackage

// File: rtl/warmboot_sequencer_if.sv
// Request/response bundle between the bootloader core, the board pins and the sequencer.
interface warmboot_sequencer_if #(
  parameter int NUM_PWR_EN = 2
);

  logic                    boot_req;
  warmboot_pkg::img_t      boot_image;
  logic [NUM_PWR_EN-1:0]   pwr_en_req;
  logic                    wdt_kick;
  logic                    usb_pu;
  logic [NUM_PWR_EN-1:0]   pwr_en;
  warmboot_pkg::img_t      wb_s;
  logic                    wb_boot;
  logic                    busy;
  logic                    req_err;

  modport master (
    output boot_req, boot_image, pwr_en_req, wdt_kick,
    input  usb_pu, pwr_en, wb_s, wb_boot, busy, req_err
  );

  modport slave (
    input  boot_req, boot_image, pwr_en_req, wdt_kick,
    output usb_pu, pwr_en, wb_s, wb_boot, busy, req_err
  );

endinterface

// File: rtl/wb_delay_counter.sv
// Loadable down-counter that stops at zero; used for sequence delays and the watchdog.
module wb_delay_counter #(
  parameter int           W         = 1,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= RESET_VAL;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/warmboot_sequencer.sv
// iCE40 multiboot sequencer: USB detach, power-off, image select, then SB_WARMBOOT BOOT.
// Optional watchdog auto-boot into the golden image is enabled by defining BOOT_WATCHDOG_EN.
module warmboot_sequencer
  import warmboot_pkg::*;
#(
  parameter int NUM_IMAGES    = 4,
  parameter int NUM_PWR_EN    = 2,
  parameter int DETACH_CYCLES = 480000,
  parameter int SETTLE_CYCLES = 4800,
  parameter int ARM_CYCLES    = 4,
  parameter int WDT_CYCLES    = 2**28 - 1
) (
  input  logic                 clk_48mhz,
  input  logic                 reset,
  warmboot_sequencer_if.slave  bus
);

  localparam int MAX_A   = (DETACH_CYCLES > SETTLE_CYCLES) ? DETACH_CYCLES : SETTLE_CYCLES;
  localparam int MAX_SEQ = (MAX_A > ARM_CYCLES) ? MAX_A : ARM_CYCLES;
  localparam int CNT_W   = cyc_w(MAX_SEQ);

  state_t             state;
  state_t             next_state;
  img_t               image;
  img_t               start_img;
  logic               start;
  logic               reject;
  logic               seq_load;
  logic [CNT_W-1:0]   seq_load_val;
  logic               seq_zero;
  logic [CNT_W-1:0]   unused_seq_count;
  logic               wdt_expire;

  wb_delay_counter #(.W(CNT_W)) u_seq_cnt (
    .clk      (clk_48mhz),
    .reset    (reset),
    .load     (seq_load),
    .load_val (seq_load_val),
    .dec      ((state != IDLE) && (state != FIRE)),
    .value    (unused_seq_count),
    .zero     (seq_zero)
  );

`ifdef BOOT_WATCHDOG_EN
  localparam int WDT_W = cyc_w(WDT_CYCLES);

  logic             wdt_zero;
  logic [WDT_W-1:0] unused_wdt_count;

  // Watchdog only runs while idle, so an in-flight sequence is never restarted by it.
  wb_delay_counter #(.W(WDT_W), .RESET_VAL(WDT_W'(WDT_CYCLES - 1))) u_wdt_cnt (
    .clk      (clk_48mhz),
    .reset    (reset),
    .load     (bus.wdt_kick),
    .load_val (WDT_W'(WDT_CYCLES - 1)),
    .dec      (state == IDLE),
    .value    (unused_wdt_count),
    .zero     (wdt_zero)
  );

  assign wdt_expire = wdt_zero && (state == IDLE);
`else
  logic unused_kick;

  assign unused_kick = bus.wdt_kick;
  assign wdt_expire  = 1'b0;
`endif

  // An explicit request always takes precedence over a watchdog expiry in the same cycle.
  always_comb begin
    next_state   = state;
    start        = 1'b0;
    reject       = 1'b0;
    start_img    = GOLDEN_IMAGE;
    seq_load     = 1'b0;
    seq_load_val = '0;
    case (state)
      IDLE: begin
        if (bus.boot_req) begin
          if (int'(bus.boot_image) < NUM_IMAGES) begin
            start     = 1'b1;
            start_img = bus.boot_image;
          end else begin
            reject = 1'b1;
          end
        end else if (wdt_expire) begin
          start = 1'b1;
        end
        if (start) begin
          next_state   = DETACH;
          seq_load     = 1'b1;
          seq_load_val = CNT_W'(DETACH_CYCLES - 1);
        end
      end
      DETACH: if (seq_zero) begin
        next_state   = PWROFF;
        seq_load     = 1'b1;
        seq_load_val = CNT_W'(SETTLE_CYCLES - 1);
      end
      PWROFF: if (seq_zero) begin
        next_state   = ARM;
        seq_load     = 1'b1;
        seq_load_val = CNT_W'(ARM_CYCLES - 1);
      end
      ARM:     if (seq_zero) next_state = FIRE;
      FIRE:    next_state = FIRE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so they line up with the state register.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state        <= IDLE;
      image        <= GOLDEN_IMAGE;
      bus.usb_pu   <= 1'b1;
      bus.pwr_en   <= '0;
      bus.wb_s     <= GOLDEN_IMAGE;
      bus.wb_boot  <= 1'b0;
      bus.busy     <= 1'b0;
      bus.req_err  <= 1'b0;
    end else begin
      state       <= next_state;
      bus.usb_pu  <= (next_state == IDLE);
      bus.busy    <= (next_state != IDLE);
      bus.req_err <= reject;
      bus.wb_boot <= (next_state == FIRE);
      if (start) begin
        image <= start_img;
      end
      if ((next_state == ARM) || (next_state == FIRE)) begin
        bus.wb_s <= image;
      end else begin
        bus.wb_s <= GOLDEN_IMAGE;
      end
      // Power enables track the user while idle, hold through detach, then drop.
      if (state == IDLE) begin
        bus.pwr_en <= bus.pwr_en_req;
      end else if (next_state != DETACH) begin
        bus.pwr_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer against a timeline-based reference model.
// Define BOOT_WATCHDOG_EN for both RTL and bench to exercise the watchdog.
module tb_warmboot_sequencer;
  import warmboot_pkg::*;

  localparam int D  = 8;
  localparam int S  = 4;
  localparam int A  = 2;
  localparam int W  = 64;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  warmboot_sequencer_if #(.NUM_PWR_EN(2)) bus ();

  warmboot_sequencer #(
    .NUM_IMAGES    (NI),
    .NUM_PWR_EN    (2),
    .DETACH_CYCLES (D),
    .SETTLE_CYCLES (S),
    .ARM_CYCLES    (A),
    .WDT_CYCLES    (W)
  ) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .bus       (bus.slave)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: elapsed cycles since the sequence started decide every output.
  bit       m_idle = 1'b1;
  int       m_e    = 0;
  int       m_img  = 0;
  bit [1:0] m_pwr  = 2'b00;
  bit       m_err  = 1'b0;
  int       m_wdt  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic modelStep(input bit rst_v, input bit req_v, input int img_v, input bit [1:0] pwr_v, input bit kick_v);
    bit was_idle;
    bit expire;
    was_idle = m_idle;
    if (rst_v) begin
      m_idle = 1'b1;
      m_pwr  = 2'b00;
      m_err  = 1'b0;
      m_wdt  = 0;
    end else begin
      m_err  = 1'b0;
      expire = 1'b0;
`ifdef BOOT_WATCHDOG_EN
      expire = (m_wdt >= W - 1);
`endif
      if (was_idle) begin
        m_pwr = pwr_v;
        if (req_v) begin
          if (img_v < NI) begin
            m_idle = 1'b0; m_e = 1; m_img = img_v;
          end else begin
            m_err = 1'b1;
          end
        end else if (expire) begin
          m_idle = 1'b0; m_e = 1; m_img = 0;
        end
      end else begin
        m_e++;
        if (m_e > D) m_pwr = 2'b00;
      end
      if (kick_v) m_wdt = 0;
      else if (was_idle && m_wdt < W - 1) m_wdt++;
    end
  endtask

  task automatic compareAll();
    bit       e_arm;
    bit       e_fire;
    e_arm  = !m_idle && (m_e > D + S);
    e_fire = !m_idle && (m_e > D + S + A);
    checkOutput("usb_pu",  32'(bus.usb_pu),  32'(m_idle));
    checkOutput("busy",    32'(bus.busy),    32'(!m_idle));
    checkOutput("pwr_en",  32'(bus.pwr_en),  32'(m_pwr));
    checkOutput("wb_s",    32'(bus.wb_s),    e_arm ? 32'(m_img) : 32'd0);
    checkOutput("wb_boot", 32'(bus.wb_boot), 32'(e_fire));
    checkOutput("req_err", 32'(bus.req_err), 32'(m_err));
  endtask

  task automatic applyStimulus(input bit rst_v, input bit req_v, input int img_v, input bit [1:0] pwr_v, input bit kick_v);
    reset          = rst_v;
    bus.boot_req   = req_v;
    bus.boot_image = img_t'(img_v);
    bus.pwr_en_req = pwr_v;
    bus.wdt_kick   = kick_v;
    modelStep(rst_v, req_v, img_v, pwr_v, kick_v);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compareAll();
  endtask

  initial begin
    int t0;
    int first;
    reset          = 1'b1;
    bus.boot_req   = 1'b0;
    bus.boot_image = '0;
    bus.pwr_en_req = '0;
    bus.wdt_kick   = 1'b0;
    @(negedge clk);
    repeat (3) applyStimulus(1, 0, 0, 2'b00, 0);

    $display("[TB] normal boot into image 2");
    applyStimulus(0, 0, 0, 2'b01, 0);
    applyStimulus(0, 0, 0, 2'b01, 0);
    t0 = cyc;
    first = -1;
    applyStimulus(0, 1, 2, 2'b01, 0);
    checkOutput("usb_pu_drop", 32'(bus.usb_pu), 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 2'b01, 0);
      if (bus.wb_boot === 1'b1 && first < 0) first = cyc;
    end
    checkOutput("boot_latency", 32'(first), 32'(t0 + 1 + D + S + A));
    checkOutput("boot_held", 32'(bus.wb_boot), 32'd1);

    $display("[TB] out-of-range image");
    applyStimulus(1, 0, 0, 2'b00, 0);
    applyStimulus(0, 0, 0, 2'b10, 0);
    applyStimulus(0, 1, 3, 2'b10, 0);
    checkOutput("req_err_pulse", 32'(bus.req_err), 32'd1);
    checkOutput("reject_busy", 32'(bus.busy), 32'd0);
    applyStimulus(0, 0, 0, 2'b10, 0);
    checkOutput("req_err_clear", 32'(bus.req_err), 32'd0);

    $display("[TB] second request during detach");
    applyStimulus(0, 1, 2, 2'b10, 0);
    repeat (3) applyStimulus(0, 0, 0, 2'b10, 0);
    applyStimulus(0, 1, 1, 2'b01, 0);
    repeat (12) applyStimulus(0, 0, 0, 2'b01, 0);
    checkOutput("wb_s_kept", 32'(bus.wb_s), 32'd2);

    $display("[TB] reset during power-off");
    applyStimulus(1, 0, 0, 2'b00, 0);
    applyStimulus(0, 1, 1, 2'b11, 0);
    repeat (10) applyStimulus(0, 0, 0, 2'b11, 0);
    applyStimulus(1, 0, 0, 2'b11, 0);
    checkOutput("abort_usb_pu", 32'(bus.usb_pu), 32'd1);
    checkOutput("abort_pwr_en", 32'(bus.pwr_en), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    applyStimulus(0, 0, 0, 2'b11, 0);
    checkOutput("pwr_follow", 32'(bus.pwr_en), 32'd3);

    $display("[TB] pwr_en_req toggling during arm");
    t0 = cyc;
    first = -1;
    applyStimulus(0, 1, 0, 2'b11, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 2'($urandom), 0);
      if (bus.wb_boot === 1'b1 && first < 0) first = cyc;
    end
    checkOutput("boot_latency_toggle", 32'(first), 32'(t0 + 1 + D + S + A));

    $display("[TB] randomized traffic");
    applyStimulus(1, 0, 0, 2'b00, 0);
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
                    int'($urandom_range(0, 3)), 2'($urandom), $urandom_range(0, 29) == 0);
    end

`ifdef BOOT_WATCHDOG_EN
    $display("[TB] watchdog expiry without kicks");
    applyStimulus(1, 0, 0, 2'b00, 0);
    t0 = cyc;
    first = -1;
    for (int i = 0; i < 90; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 0);
      if (bus.busy === 1'b1 && first < 0) first = cyc;
    end
    checkOutput("wdt_start", 32'(first), 32'(t0 + W));
    checkOutput("wdt_golden", 32'(bus.wb_s), 32'(GOLDEN_IMAGE));

    $display("[TB] watchdog kicked every 50 cycles");
    applyStimulus(1, 0, 0, 2'b00, 0);
    first = -1;
    for (int i = 0; i < 250; i++) begin
      applyStimulus(0, 0, 0, 2'b00, (i % 50) == 49);
      if (bus.busy === 1'b1 && first < 0) first = cyc;
    end
    checkOutput("wdt_kicked_idle", 32'(first), 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
